// File: rtl/xb_cmd_sched.sv
// Command sequencer and read-FIFO write-port arbiter for the Xillybus command/read FIFO pair.
// Run words appear one cycle after the consuming edge; out_full stalls every source with state held.
module xb_cmd_sched #(
  parameter int CNT_W = 28
) (
  input  logic        bus_clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_data,
  input  logic        cmd_empty,
  output logic        cmd_ack,
  output logic [31:0] out_data,
  output logic        out_wren,
  input  logic        out_full,
  input  logic        ext_req,
  input  logic [31:0] ext_data,
  output logic        ext_grant,
  output logic        eof,
  output logic        busy,
  output logic [7:0]  bad_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, REPLY} state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      reply;
  logic             ext_en;
  logic             last_ext;

  logic [3:0]       opcode;
  logic [CNT_W-1:0] payload;
  logic             pop;
  logic             int_v;
  logic             ext_v;
  logic             sel_ext;
  logic             int_wr;
  logic [31:0]      int_word;

  assign opcode  = cmd_data[31:28];
  assign payload = cmd_data[CNT_W-1:0];

  // cmd_ack doubles as the guard: the FIFO head is stale while the pop strobe is in flight
  assign pop = ~cmd_empty & ~cmd_ack &
               ((state == IDLE) | ((state == RUN) & (opcode == 4'h0)));

  assign int_v    = (state == RUN) | (state == REPLY);
  assign ext_v    = ext_req & ext_en;
  assign sel_ext  = ext_v & (~int_v | ~last_ext);
  assign int_word = (state == RUN) ? {4'h1, remaining} : reply;

  always_comb begin
    out_data = 32'h0;
    if (sel_ext)
      out_data = ext_data;
    else if (int_v)
      out_data = int_word;
  end

  assign out_wren  = (int_v | ext_v) & ~out_full;
  assign ext_grant = out_wren & sel_ext;
  assign int_wr    = out_wren & ~sel_ext;

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      reply     <= 32'h0;
      ext_en    <= 1'b0;
      eof       <= 1'b0;
      bad_cnt   <= 8'h00;
      cmd_ack   <= 1'b0;
      last_ext  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      cmd_ack <= pop;
      if (out_wren)
        last_ext <= sel_ext;

      case (state)
        IDLE: begin
          if (pop) begin
            case (opcode)
              4'h0: eof <= 1'b1;
              4'h1: begin
                if (payload != '0) begin
                  remaining <= payload;
                  eof       <= 1'b0;
                  state     <= RUN;
                  busy      <= 1'b1;
                end
              end
              4'h2: begin
                reply <= cmd_data;
                state <= REPLY;
                busy  <= 1'b1;
              end
              4'h3: begin
                reply <= {4'h3, ext_en, eof, 2'b00, bad_cnt, 16'h0000};
                state <= REPLY;
                busy  <= 1'b1;
              end
              4'h4: ext_en <= cmd_data[0];
              default: begin
                if (bad_cnt != 8'hFF)
                  bad_cnt <= bad_cnt + 8'd1;
              end
            endcase
          end
        end
        RUN: begin
          // a STOP abort overrides any decrement from a same-cycle write
          if (pop) begin
            remaining <= '0;
            eof       <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (int_wr) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        REPLY: begin
          if (int_wr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xb_cmd_sched.sv
// Directed bench for xb_cmd_sched with a first-word fall-through command FIFO model.
module tb_xb_cmd_sched;

  logic        bus_clk = 1'b0;
  logic        reset_n;
  logic [31:0] cmd_data;
  logic        cmd_empty;
  logic        cmd_ack;
  logic [31:0] out_data;
  logic        out_wren;
  logic        out_full;
  logic        ext_req;
  logic [31:0] ext_data;
  logic        ext_grant;
  logic        eof;
  logic        busy;
  logic [7:0]  bad_cnt;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          cyc      = 0;
  logic [31:0] cmdq[$];
  logic [31:0] wdat[$];
  logic        wgnt[$];
  int          wcyc[$];
  logic        first_ack;

  xb_cmd_sched #(.CNT_W(28)) dut (
    .bus_clk(bus_clk), .reset_n(reset_n), .cmd_data(cmd_data), .cmd_empty(cmd_empty),
    .cmd_ack(cmd_ack), .out_data(out_data), .out_wren(out_wren), .out_full(out_full),
    .ext_req(ext_req), .ext_data(ext_data), .ext_grant(ext_grant), .eof(eof),
    .busy(busy), .bad_cnt(bad_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic refresh();
    cmd_empty = (cmdq.size() == 0);
    cmd_data  = cmd_empty ? 32'h0 : cmdq[0];
  endtask

  task automatic push(input logic [31:0] w);
    cmdq.push_back(w);
    refresh();
  endtask

  task automatic clear_log();
    wdat.delete();
    wgnt.delete();
    wcyc.delete();
    first_ack = 1'b0;
  endtask

  // one clock: log the write that the coming edge performs, then retire any acked command
  task automatic step();
    logic [31:0] tmp;
    #2;
    if (out_wren) begin
      wdat.push_back(out_data);
      wgnt.push_back(ext_grant);
      wcyc.push_back(cyc);
      if (wdat.size() == 1) first_ack = cmd_ack;
    end
    @(posedge bus_clk);
    #1;
    cyc++;
    if (cmd_ack && cmdq.size() > 0) tmp = cmdq.pop_front();
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; out_full = 1'b0; ext_req = 1'b0; ext_data = 32'h0;
    refresh();
    @(posedge bus_clk);
    #1;
    chk_cnt++; if (out_wren !== 1'b0) $display("FAIL reset_wren got %b exp 0", out_wren); else pass_cnt++;
    chk_cnt++; if (ext_grant !== 1'b0) $display("FAIL reset_grant got %b exp 0", ext_grant); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (eof !== 1'b0) $display("FAIL reset_eof got %b exp 0", eof); else pass_cnt++;
    chk_cnt++; if (bad_cnt !== 8'h00) $display("FAIL reset_bad_cnt got %h exp 00", bad_cnt); else pass_cnt++;
    chk_cnt++; if (cmd_ack !== 1'b0) $display("FAIL reset_ack got %b exp 0", cmd_ack); else pass_cnt++;
    chk_cnt++; if (out_data !== 32'h0) $display("FAIL reset_data got %h exp 0", out_data); else pass_cnt++;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_run3();
    clear_log();
    push(32'h10000003);
    run(6);
    chk_cnt++; if (wdat.size() != 3) $display("FAIL run3_count got %0d exp 3", wdat.size()); else pass_cnt++;
    chk_cnt++; if (wdat[0] !== 32'h10000003) $display("FAIL run3_w0 got %h exp 10000003", wdat[0]); else pass_cnt++;
    chk_cnt++; if (wdat[1] !== 32'h10000002) $display("FAIL run3_w1 got %h exp 10000002", wdat[1]); else pass_cnt++;
    chk_cnt++; if (wdat[2] !== 32'h10000001) $display("FAIL run3_w2 got %h exp 10000001", wdat[2]); else pass_cnt++;
    chk_cnt++; if (first_ack !== 1'b1) $display("FAIL run3_first_word_cycle ack got %b exp 1", first_ack); else pass_cnt++;
    chk_cnt++; if (wcyc[2] - wcyc[0] != 2) $display("FAIL run3_consecutive span got %0d exp 2", wcyc[2] - wcyc[0]); else pass_cnt++;
    chk_cnt++; if (wgnt[0] !== 1'b0) $display("FAIL run3_grant got %b exp 0", wgnt[0]); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL run3_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (eof !== 1'b0) $display("FAIL run3_eof got %b exp 0", eof); else pass_cnt++;
  endtask

  task automatic test_stall();
    clear_log();
    push(32'h10000004);
    run(2);
    out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk_cnt++; if (out_wren !== 1'b0) $display("FAIL stall_wren%0d got %b exp 0", i, out_wren); else pass_cnt++;
      chk_cnt++; if (out_data !== 32'h10000003) $display("FAIL stall_hold%0d got %h exp 10000003", i, out_data); else pass_cnt++;
      step();
    end
    out_full = 1'b0;
    run(6);
    chk_cnt++; if (wdat.size() != 4) $display("FAIL stall_count got %0d exp 4", wdat.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (wdat[i] !== (32'h10000004 - 32'(i))) $display("FAIL stall_w%0d got %h exp %h", i, wdat[i], 32'h10000004 - 32'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_stop();
    clear_log();
    push(32'h10000064);
    run(11);
    chk_cnt++; if (wdat.size() != 10) $display("FAIL stop_pre_count got %0d exp 10", wdat.size()); else pass_cnt++;
    push(32'h00000000);
    run(5);
    chk_cnt++; if (wdat.size() != 11) $display("FAIL stop_post_count got %0d exp 11", wdat.size()); else pass_cnt++;
    chk_cnt++; if (wdat[10] !== 32'h1000005A) $display("FAIL stop_last_word got %h exp 1000005a", wdat[10]); else pass_cnt++;
    chk_cnt++; if (eof !== 1'b1) $display("FAIL stop_eof got %b exp 1", eof); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL stop_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (cmdq.size() != 0) $display("FAIL stop_popped queue %0d exp 0", cmdq.size()); else pass_cnt++;
    clear_log();
    push(32'h10000001);
    run(4);
    chk_cnt++; if (wdat.size() != 1) $display("FAIL rerun_count got %0d exp 1", wdat.size()); else pass_cnt++;
    chk_cnt++; if (wdat[0] !== 32'h10000001) $display("FAIL rerun_word got %h exp 10000001", wdat[0]); else pass_cnt++;
    chk_cnt++; if (eof !== 1'b0) $display("FAIL rerun_eof got %b exp 0", eof); else pass_cnt++;
  endtask

  task automatic test_ext_arb();
    logic [31:0] exp_d [10];
    int n_int;
    clear_log();
    push(32'h40000001);
    run(2);
    chk_cnt++; if (wdat.size() != 0) $display("FAIL ext_en_nowrite got %0d exp 0", wdat.size()); else pass_cnt++;
    ext_data = 32'hE0000000;
    ext_req  = 1'b1;
    push(32'h10000004);
    run(10);
    for (int i = 0; i < 10; i++)
      exp_d[i] = (i % 2 == 0 || i >= 8) ? 32'hE0000000 : (32'h10000004 - 32'(i / 2));
    chk_cnt++; if (wdat.size() != 10) $display("FAIL arb_count got %0d exp 10", wdat.size()); else pass_cnt++;
    n_int = 0;
    for (int i = 0; i < 10; i++) begin
      if (wdat[i] !== 32'hE0000000) n_int++;
      chk_cnt++;
      if (wdat[i] !== exp_d[i] || wgnt[i] !== (exp_d[i] == 32'hE0000000))
        $display("FAIL arb_w%0d got %h/%b exp %h/%b", i, wdat[i], wgnt[i], exp_d[i], exp_d[i] == 32'hE0000000);
      else pass_cnt++;
    end
    chk_cnt++; if (n_int != 4) $display("FAIL arb_int_total got %0d exp 4", n_int); else pass_cnt++;
    out_full = 1'b1;
    #2;
    chk_cnt++; if (ext_grant !== 1'b0) $display("FAIL full_grant got %b exp 0", ext_grant); else pass_cnt++;
    chk_cnt++; if (out_wren !== 1'b0) $display("FAIL full_wren got %b exp 0", out_wren); else pass_cnt++;
    step();
    out_full = 1'b0;
    ext_req  = 1'b0;
  endtask

  task automatic test_echo_status();
    clear_log();
    push(32'h2ABCDEF0);
    run(4);
    chk_cnt++; if (wdat.size() != 1) $display("FAIL echo_count got %0d exp 1", wdat.size()); else pass_cnt++;
    chk_cnt++; if (wdat[0] !== 32'h2ABCDEF0) $display("FAIL echo_word got %h exp 2abcdef0", wdat[0]); else pass_cnt++;
    push(32'h70000000);
    run(3);
    chk_cnt++; if (bad_cnt !== 8'd1) $display("FAIL bad_cnt got %0d exp 1", bad_cnt); else pass_cnt++;
    chk_cnt++; if (wdat.size() != 1) $display("FAIL bad_nowrite got %0d exp 1", wdat.size()); else pass_cnt++;
    clear_log();
    push(32'h30000000);
    run(4);
    chk_cnt++; if (wdat.size() != 1) $display("FAIL status_count got %0d exp 1", wdat.size()); else pass_cnt++;
    chk_cnt++; if (wdat[0] !== 32'h38010000) $display("FAIL status_word got %h exp 38010000", wdat[0]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    clear_log();
    push(32'h10000032);
    push(32'h10000002);
    run(6);
    chk_cnt++; if (wdat.size() != 5) $display("FAIL midrst_pre_count got %0d exp 5", wdat.size()); else pass_cnt++;
    ext_data = 32'hE0000000;
    ext_req  = 1'b1;
    reset_n  = 1'b0;
    #1;
    chk_cnt++; if (out_wren !== 1'b0) $display("FAIL midrst_wren got %b exp 0", out_wren); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (bad_cnt !== 8'h00) $display("FAIL midrst_bad_cnt got %0d exp 0", bad_cnt); else pass_cnt++;
    chk_cnt++; if (ext_grant !== 1'b0) $display("FAIL midrst_grant got %b exp 0", ext_grant); else pass_cnt++;
    run(2);
    reset_n = 1'b1;
    clear_log();
    run(6);
    chk_cnt++; if (wdat.size() != 2) $display("FAIL postrst_count got %0d exp 2", wdat.size()); else pass_cnt++;
    chk_cnt++; if (wdat[0] !== 32'h10000002) $display("FAIL postrst_w0 got %h exp 10000002", wdat[0]); else pass_cnt++;
    chk_cnt++; if (wdat[1] !== 32'h10000001) $display("FAIL postrst_w1 got %h exp 10000001", wdat[1]); else pass_cnt++;
    chk_cnt++; if (wgnt[0] !== 1'b0 || wgnt[1] !== 1'b0) $display("FAIL postrst_ext_en grants %b%b exp 00", wgnt[0], wgnt[1]); else pass_cnt++;
    ext_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run3();
    test_stall();
    test_stop();
    test_ext_arb();
    test_echo_status();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d cycles", cyc);
    $fatal(1, "timeout");
  end

endmodule
